// File: rtl/ps_pad_responder.sv
// ps_pad_responder: device side of the DUALSHOCK pad link. Answers the
// 5-byte digital poll (01 42 xx vs vl) with ID 41, 5A and the latched
// buttons, and captures the two vibration bytes. All link inputs are
// oversampled on clk through a synchronizer chain.
module ps_pad_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY   = 32,
    parameter int ACK_WIDTH   = 24
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        sclk,
    input  logic        n_sel,
    input  logic        cmd,
    output logic        dat,
    output logic        n_ack,
    input  logic [15:0] buttons,
    output logic [7:0]  vib_small,
    output logic [7:0]  vib_large,
    output logic        poll_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_XFER   = 2'd1;
    localparam logic [1:0] S_IGNORE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] A_OFF  = 2'd0;
    localparam logic [1:0] A_WAIT = 2'd1;
    localparam logic [1:0] A_LOW  = 2'd2;

    localparam int ACK_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CW      = $clog2(ACK_MAX + 1);

    logic [SYNC_STAGES-1:0] sclk_sq, nsel_sq, cmd_sq;
    logic sclk_pq, nsel_pq;
    logic sclk_s, nsel_s, cmd_s;
    logic sclk_fall, sclk_rise, nsel_fall, nsel_rise;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    tx_q, tx_d, rx_q, rx_d, hold_q, hold_d;
    logic [15:0]   latch_q, latch_d;
    logic          dat_q, dat_d, nack_q, nack_d, pd_q, pd_d;
    logic [7:0]    vs_q, vs_d, vl_q, vl_d;
    logic [1:0]    ack_st_q, ack_st_d;
    logic [CW-1:0] ack_cnt_q, ack_cnt_d;

    logic [7:0] rx_full, tx_next;
    logic       pass;

    assign sclk_s    = sclk_sq[SYNC_STAGES-1];
    assign nsel_s    = nsel_sq[SYNC_STAGES-1];
    assign cmd_s     = cmd_sq[SYNC_STAGES-1];
    assign sclk_fall = sclk_pq & ~sclk_s;
    assign sclk_rise = ~sclk_pq & sclk_s;
    // n_sel chain resets low so a select held low through reset is not
    // mistaken for a fresh falling edge after release.
    assign nsel_fall = nsel_pq & ~nsel_s;
    assign nsel_rise = ~nsel_pq & nsel_s;

    // Synchronizer chains plus one previous-value flop for edge detection.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sclk_sq <= '1;
            nsel_sq <= '0;
            cmd_sq  <= '1;
            sclk_pq <= 1'b1;
            nsel_pq <= 1'b0;
        end else begin
            sclk_sq <= (sclk_sq << 1) | SYNC_STAGES'(sclk);
            nsel_sq <= (nsel_sq << 1) | SYNC_STAGES'(n_sel);
            cmd_sq  <= (cmd_sq << 1)  | SYNC_STAGES'(cmd);
            sclk_pq <= sclk_s;
            nsel_pq <= nsel_s;
        end
    end

    // Protocol FSM, byte evaluation and ack timer next-state logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        hold_d     = hold_q;
        latch_d    = latch_q;
        dat_d      = dat_q;
        nack_d     = nack_q;
        pd_d       = 1'b0;
        vs_d       = vs_q;
        vl_d       = vl_q;
        ack_st_d   = ack_st_q;
        ack_cnt_d  = ack_cnt_q;
        rx_full    = {cmd_s, rx_q[6:0]};
        tx_next    = 8'hFF;
        pass       = 1'b1;

        case (ack_st_q)
            A_WAIT: begin
                if (ack_cnt_q == '0) begin
                    ack_st_d  = A_LOW;
                    ack_cnt_d = CW'(ACK_WIDTH - 1);
                    nack_d    = 1'b0;
                end else begin
                    ack_cnt_d = ack_cnt_q - 1'b1;
                end
            end
            A_LOW: begin
                if (ack_cnt_q == '0) begin
                    ack_st_d = A_OFF;
                    nack_d   = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
        // Host already clocking the next byte: drop any pending/active ack.
        if (sclk_fall && ack_st_q != A_OFF) begin
            ack_st_d = A_OFF;
            nack_d   = 1'b1;
        end

        if (nsel_rise) begin
            state_d    = S_IDLE;
            dat_d      = 1'b1;
            nack_d     = 1'b1;
            ack_st_d   = A_OFF;
            bit_cnt_d  = '0;
            byte_idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dat_d    = 1'b1;
                    nack_d   = 1'b1;
                    ack_st_d = A_OFF;
                    if (nsel_fall) begin
                        byte_idx_d = '0;
                        bit_cnt_d  = '0;
                        tx_d       = 8'hFF;
                        dat_d      = 1'b1;
                        state_d    = S_XFER;
                    end
                end
                S_XFER: begin
                    if (sclk_fall) begin
                        if (bit_cnt_q != '0) dat_d = tx_q[bit_cnt_q];
                    end else if (sclk_rise) begin
                        rx_d[bit_cnt_q] = cmd_s;
                        bit_cnt_d       = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            case (byte_idx_q)
                                3'd0: if (rx_full != 8'h01) pass = 1'b0;
                                      else tx_next = 8'h41;
                                3'd1: if (rx_full != 8'h42) pass = 1'b0;
                                      else begin
                                          latch_d = buttons;
                                          tx_next = 8'h5A;
                                      end
                                3'd2: tx_next = latch_q[7:0];
                                3'd3: begin
                                    hold_d  = rx_full;
                                    tx_next = latch_q[15:8];
                                end
                                3'd4: begin
                                    vs_d = hold_q;
                                    vl_d = rx_full;
                                    pd_d = 1'b1;
                                end
                                default: pass = 1'b0;
                            endcase
                            if (!pass || byte_idx_q == 3'd4) begin
                                state_d  = pass ? S_DONE : S_IGNORE;
                                dat_d    = 1'b1;
                                nack_d   = 1'b1;
                                ack_st_d = A_OFF;
                            end else begin
                                tx_d       = tx_next;
                                dat_d      = tx_next[0];
                                byte_idx_d = byte_idx_q + 1'b1;
                                ack_st_d   = A_WAIT;
                                ack_cnt_d  = CW'(ACK_DELAY - 1);
                                nack_d     = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    dat_d    = 1'b1;
                    nack_d   = 1'b1;
                    ack_st_d = A_OFF;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 8'hFF;
            rx_q       <= '0;
            hold_q     <= '0;
            latch_q    <= 16'hFFFF;
            dat_q      <= 1'b1;
            nack_q     <= 1'b1;
            pd_q       <= 1'b0;
            vs_q       <= '0;
            vl_q       <= '0;
            ack_st_q   <= A_OFF;
            ack_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            hold_q     <= hold_d;
            latch_q    <= latch_d;
            dat_q      <= dat_d;
            nack_q     <= nack_d;
            pd_q       <= pd_d;
            vs_q       <= vs_d;
            vl_q       <= vl_d;
            ack_st_q   <= ack_st_d;
            ack_cnt_q  <= ack_cnt_d;
        end
    end

    assign dat       = dat_q;
    assign n_ack     = nack_q;
    assign poll_done = pd_q;
    assign vib_small = vs_q;
    assign vib_large = vl_q;

endmodule
